wb_accel_dispatch: RTL
======================

# wb_accel_dispatch

Parametrised Wishbone dispatcher that sits between a compute tile's network-adapter Wishbone master and NR_ACCEL accelerator slaves, such as modexp instances. It decodes the request address into one of NR_ACCEL accelerator windows or one local control page. It runs each transaction through a single-outstanding FSM with a per-access timeout, and aggregates accelerator completion into sticky status bits and one interrupt.

## Interface
Parameters:
- NR_ACCEL, 2: number of accelerator slaves, legal range 1..8.
- WIN_BITS, 12: log2 of each window size in bytes.
- BASE_ADDR, 32'h0000_0000: base of window 0. Must be aligned to 2^WIN_BITS.
- TIMEOUT, 255: maximum cycles in ACCESS before abort, legal range 1..65535.

Ports:
- clk  in  1  single clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- wbs_adr_i  in  32  request address.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte selects.
- wbs_we_i  in  1  write enable.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_dat_o  out  32  read data; valid while wbs_ack_o is high.
- wbs_ack_o  out  1  one-cycle completion.
- wbs_err_o  out  1  one-cycle error completion.
- acc_adr_o  out  32  latched full address; shared by all accelerators.
- acc_dat_o  out  32  latched write data; shared.
- acc_sel_o  out  4  latched byte selects; shared.
- acc_we_o  out  1  latched write enable; shared.
- acc_cyc_o  out  NR_ACCEL  per-accelerator cycle, one-hot or zero.
- acc_stb_o  out  NR_ACCEL  per-accelerator strobe; equals acc_cyc_o.
- acc_dat_i  in  32*NR_ACCEL  read data; accelerator k uses bits [32k+31:32k].
- acc_ack_i  in  NR_ACCEL  per-accelerator ack.
- acc_err_i  in  NR_ACCEL  per-accelerator error.
- acc_done_i  in  NR_ACCEL  level completion flag per accelerator.
- irq  out  1  registered interrupt.

## Operation
- Decode: region = (wbs_adr_i - BASE_ADDR) >> WIN_BITS.
  - region < NR_ACCEL: accelerator `region`.
  - region == NR_ACCEL: control page.
  - Any other region, or an address below BASE_ADDR: unmapped.
- Control page, offsets taken within the page:
  - 0x0 STATUS [NR_ACCEL-1:0]: sticky done bits. Read returns them; write-1-to-clear under wbs_sel_i[0].
  - 0x4 IRQ_EN [NR_ACCEL-1:0]: read/write, reset 0.
  - 0x8 TO_CNT [15:0]: read-only count of timeouts; saturates at 0xFFFF.
  - Other offsets: reads return 0, writes are ignored, ack is given (not err).
- FSM states: IDLE, ACCESS, RESP.
  - IDLE, on cyc&stb: latch adr, dat, sel, we, and the decoded target.
    - Accelerator target → ACCESS; acc_cyc_o/acc_stb_o bit k is high from the next cycle.
    - Control target → RESP with ack; a control write takes effect at this edge.
    - Unmapped → RESP with err.
  - ACCESS, timer counts from 0:
    - acc_ack_i[k] → RESP with ack; acc_dat_i slice k is captured into wbs_dat_o.
    - acc_err_i[k] → RESP with err.
    - Timer reaching TIMEOUT-1 with neither ack nor err → RESP with err; TO_CNT increments.
    - wbs_cyc_i dropping → IDLE with no response.
    - All exits deassert acc_cyc_o/acc_stb_o at the same edge.
  - RESP: wbs_ack_o or wbs_err_o is high for exactly this one cycle, then → IDLE.
- Done tracking:
  - A rising edge of acc_done_i[k] (registered previous value) sets STATUS[k].
  - If a set and a W1C of the same bit occur in the same cycle, set wins.
- irq is a register: irq <= |(STATUS & IRQ_EN).

## Timing
- Reset values: all outputs 0, state IDLE, STATUS 0, IRQ_EN 0, TO_CNT 0, timer 0, done history 0.
- Control or unmapped access: stb sampled at edge E0; ack/err high during cycle E0→E1. Latency is 1 cycle.
- Accelerator access:
  - acc_stb_o is high from E0.
  - If the accelerator acks during cycle j (j = 0 means same cycle as first stb), wbs_ack_o is high during cycle j+1.
  - Total latency = j + 2 cycles.
- Ack or err arriving in the same cycle as timer == TIMEOUT-1: the accelerator response wins and TO_CNT is unchanged.
- ack and err asserted together by an accelerator: err wins.
- Only acc_*_i bit k of the selected accelerator is observed; other bits are ignored.
- Only one transaction is outstanding. wbs_stb_i is not sampled in ACCESS or RESP; the next request is sampled in IDLE.
- irq lags the STATUS change by one cycle and the acc_done_i edge by two cycles.
- rst while in ACCESS: acc_cyc_o drops at that edge, no wbs ack/err is produced, and STATUS, IRQ_EN and TO_CNT are cleared.

## Test plan
Settings for all scenarios: NR_ACCEL=2, WIN_BITS=12, BASE_ADDR=0, TIMEOUT=16.
- Write 0x000000AA to 0x010; accelerator 0 acks in cycle j=3 → acc_cyc_o=2'b01 with acc_adr_o=0x010 and acc_dat_o=0xAA; wbs_ack_o high 1 cycle, 5 cycles after stb was sampled.
- Read 0x1004; accelerator 1 returns 0xDEADBEEF with ack at j=0 → acc_cyc_o=2'b10; wbs_dat_o=0xDEADBEEF with ack 2 cycles after stb was sampled.
- Read 0x1000 with accelerator 1 never responding → wbs_err_o after 17 cycles and acc_cyc_o drops; a read of 0x2008 then returns 1. Also ack exactly at timer=15 → ack, TO_CNT unchanged.
- Access 0x3000 → wbs_err_o 1 cycle later and acc_cyc_o stays 0. Read 0x200C → 0 with ack.
- Write 0x2 to 0x2004, then pulse acc_done_i[1] → STATUS reads 0x2 and irq is high 2 cycles after the edge. Write 0x2 to 0x2000 → irq low. A W1C coincident with a new edge → bit stays set.
- Assert rst, or drop wbs_cyc_i, during ACCESS → acc_cyc_o=0 on the next edge and no ack/err; a following access to 0x000 completes normally.

Source files
------------

// File: rtl/wb_accel_dispatch.sv
// Wishbone dispatcher to NR_ACCEL accelerator windows plus a local control page.
// Latency: 1 cycle for control/unmapped, j+2 for accelerators; single-outstanding, stb ignored until IDLE.
module wb_accel_dispatch #(
    parameter int unsigned NR_ACCEL  = 2,
    parameter int unsigned WIN_BITS  = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic                     wbs_we_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    output logic [31:0]              wbs_dat_o,
    output logic                     wbs_ack_o,
    output logic                     wbs_err_o,
    output logic [31:0]              acc_adr_o,
    output logic [31:0]              acc_dat_o,
    output logic [3:0]               acc_sel_o,
    output logic                     acc_we_o,
    output logic [NR_ACCEL-1:0]      acc_cyc_o,
    output logic [NR_ACCEL-1:0]      acc_stb_o,
    input  logic [32*NR_ACCEL-1:0]   acc_dat_i,
    input  logic [NR_ACCEL-1:0]      acc_ack_i,
    input  logic [NR_ACCEL-1:0]      acc_err_i,
    input  logic [NR_ACCEL-1:0]      acc_done_i,
    output logic                     irq
);
    localparam int unsigned IW = (NR_ACCEL > 1) ? $clog2(NR_ACCEL) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [31:0]         adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
    logic [3:0]          sel_q, sel_d;
    logic                we_q, we_d, ack_q, ack_d, err_q, err_d, irq_q;
    logic [IW-1:0]       tgt_q, tgt_d;
    logic [15:0]         timer_q, timer_d, to_cnt_q, to_cnt_d;
    logic [NR_ACCEL-1:0] status_q, status_d, irq_en_q, irq_en_d, done_prev_q, w1c;

    logic [31:0]         rel, region, ctl_rdat;
    logic [WIN_BITS-1:0] page_off;
    logic                below, hit_acc, hit_ctl, ack_k, err_k;
    logic [31:0]         dat_k;

    assign rel      = wbs_adr_i - BASE_ADDR;
    assign region   = rel >> WIN_BITS;
    assign page_off = rel[WIN_BITS-1:0];
    assign below    = wbs_adr_i < BASE_ADDR;
    assign hit_acc  = !below && (region < NR_ACCEL);
    assign hit_ctl  = !below && (region == NR_ACCEL);

    // Only the selected accelerator's response lines are observed.
    assign ack_k = acc_ack_i[tgt_q];
    assign err_k = acc_err_i[tgt_q];
    assign dat_k = acc_dat_i[32*tgt_q +: 32];

    always_comb begin
        ctl_rdat = '0;
        if (page_off == WIN_BITS'(0))
            ctl_rdat[NR_ACCEL-1:0] = status_q;
        else if (page_off == WIN_BITS'(4))
            ctl_rdat[NR_ACCEL-1:0] = irq_en_q;
        else if (page_off == WIN_BITS'(8))
            ctl_rdat[15:0] = to_cnt_q;
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        tgt_d    = tgt_q;
        timer_d  = timer_q;
        to_cnt_d = to_cnt_q;
        irq_en_d = irq_en_q;
        rdat_d   = '0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        w1c      = '0;
        case (state_q)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    adr_d = wbs_adr_i;
                    dat_d = wbs_dat_i;
                    sel_d = wbs_sel_i;
                    we_d  = wbs_we_i;
                    tgt_d = region[IW-1:0];
                    if (hit_acc) begin
                        state_d = S_ACCESS;
                        timer_d = '0;
                    end else if (hit_ctl) begin
                        state_d = S_RESP;
                        ack_d   = 1'b1;
                        if (!wbs_we_i) begin
                            rdat_d = ctl_rdat;
                        end else if (wbs_sel_i[0]) begin
                            if (page_off == WIN_BITS'(0))
                                w1c = wbs_dat_i[NR_ACCEL-1:0];
                            if (page_off == WIN_BITS'(4))
                                irq_en_d = wbs_dat_i[NR_ACCEL-1:0];
                        end
                    end else begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                timer_d = timer_q + 16'd1;
                // An abandoned cycle beats any response; err beats ack; both beat the timeout.
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (err_k) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else if (ack_k) begin
                    state_d = S_RESP;
                    ack_d   = 1'b1;
                    rdat_d  = dat_k;
                end else if (timer_q == 16'(TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    if (to_cnt_q != 16'hFFFF)
                        to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Set after clear so a coincident done edge survives a W1C.
        status_d = (status_q & ~w1c) | (acc_done_i & ~done_prev_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            tgt_q       <= '0;
            timer_q     <= '0;
            to_cnt_q    <= '0;
            irq_en_q    <= '0;
            status_q    <= '0;
            done_prev_q <= '0;
            rdat_q      <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            tgt_q       <= tgt_d;
            timer_q     <= timer_d;
            to_cnt_q    <= to_cnt_d;
            irq_en_q    <= irq_en_d;
            status_q    <= status_d;
            done_prev_q <= acc_done_i;
            rdat_q      <= rdat_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            irq_q       <= |(status_q & irq_en_q);
        end
    end

    assign acc_cyc_o = (state_q == S_ACCESS) ? (NR_ACCEL'(1) << tgt_q) : '0;
    assign acc_stb_o = acc_cyc_o;
    assign acc_adr_o = adr_q;
    assign acc_dat_o = dat_q;
    assign acc_sel_o = sel_q;
    assign acc_we_o  = we_q;
    assign wbs_dat_o = rdat_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign irq       = irq_q;
endmodule
